// File: rtl/prueba_adc_if.sv
// prueba_adc_if: pin-level bundle between the serial-ADC front end and its neighbours
interface prueba_adc_if;
  logic        data_ADC;
  logic        start;
  logic        done;
  logic        CS;
  logic        Clock_Muestreo;
  logic [3:0]  data_basura;
  logic [11:0] Dato;
  modport master(input data_ADC, start, output done, CS, Clock_Muestreo, data_basura, Dato);
  modport slave(output data_ADC, start, input done, CS, Clock_Muestreo, data_basura, Dato);
endinterface

// File: rtl/prueba_adc.sv
// prueba_adc: AD7476-style serial ADC front end (SCLK generation, CS framing, 16-bit shift-in)
module prueba_adc #(
  parameter int CLK_DIV    = 5,
  parameter int FRAME_BITS = 16
) (
  input logic          Clock_Nexys,
  input logic          Reset,
  input logic          reset_Clck,
  prueba_adc_if.master bus
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic [FRAME_BITS-1:0] sr;
  logic [11:0] dato;
  logic [3:0] basura;
  logic sclk, wrap, rise_tick, fall_tick, quiet, done;
  assign wrap      = cnt == DIV_LAST;
  assign rise_tick = wrap && !sclk && !reset_Clck && !Reset;
  assign fall_tick = wrap && sclk && !reset_Clck && !Reset;
  always_ff @(posedge Clock_Nexys or posedge Reset or posedge reset_Clck)
    if (Reset || reset_Clck) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= !sclk;
    end else
      cnt <= cnt + 1'b1;
  always_ff @(posedge Clock_Nexys or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = (bus.start && !sclk && quiet) ? CONV : IDLE;
    else if (state == CONV) state_n = (rise_tick && bcnt == LAST_BIT) ? FINISH : CONV;
    else state_n = fall_tick ? IDLE : FINISH;
  end
  // quiet re-arms only after a full SCLK period with CS high following a frame
  always_ff @(posedge Clock_Nexys or posedge Reset)
    if (Reset) begin
      sr     <= '0;
      bcnt   <= '0;
      dato   <= '0;
      basura <= '0;
      done   <= 1'b0;
      quiet  <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state == IDLE && state_n == CONV) begin
        bcnt  <= '0;
        quiet <= 1'b0;
      end else if (state == IDLE && fall_tick)
        quiet <= 1'b1;
      if (state == CONV && rise_tick) begin
        sr   <= {sr[FRAME_BITS-2:0], bus.data_ADC};
        bcnt <= bcnt + 1'b1;
      end
      if (state == FINISH && fall_tick) begin
        basura <= sr[FRAME_BITS-1 -: 4];
        dato   <= sr[11:0];
        done   <= 1'b1;
      end
    end
  assign bus.CS             = state == IDLE;
  assign bus.Clock_Muestreo = sclk;
  assign bus.done           = done;
  assign bus.Dato           = dato;
  assign bus.data_basura    = basura;
endmodule

// File: tb/tb_prueba_adc.sv
// tb_prueba_adc: directed frames against a behavioural ADC with a result scoreboard
module tb_prueba_adc;
  logic clk = 1'b0;
  logic Reset, reset_Clck;
  always #5 clk = !clk;
  prueba_adc_if bus();
  prueba_adc #(.CLK_DIV(5), .FRAME_BITS(16)) dut (
    .Clock_Nexys(clk), .Reset(Reset), .reset_Clck(reset_Clck), .bus(bus)
  );
  int checks = 0, failures = 0;
  logic [15:0] words_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] adc_sr = '0;
  assign bus.data_ADC = adc_sr[15];
  // ADC model: frame word loaded on CS fall, next bit presented after each SCLK fall
  always @(negedge bus.CS) adc_sr = words_q.size() != 0 ? words_q.pop_front() : 16'h0000;
  always @(negedge bus.Clock_Muestreo) if (!bus.CS) adc_sr = {adc_sr[14:0], 1'b0};
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  logic prev_sclk = 1'b0, prev_cs = 1'b1, prev_done = 1'b0;
  int rises = 0, cs_high = 0;
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("frame_result", 32'({bus.data_basura, bus.Dato}), 32'(exp_q.pop_front()));
      check("cs_high_at_done", 32'(bus.CS), 32'd1);
      check("sclk_rises_in_frame", 32'(rises), 32'd16);
    end
    if (prev_done) check("done_width", 32'(bus.done), 32'd0);
    if (prev_cs && !bus.CS) begin
      check("quiet_time", 32'(cs_high >= 10), 32'd1);
      rises = 0;
    end
    if (!bus.CS && !prev_sclk && bus.Clock_Muestreo) rises++;
    cs_high = bus.CS ? cs_high + 1 : 0;
    prev_sclk = bus.Clock_Muestreo;
    prev_cs   = bus.CS;
    prev_done = bus.done;
  end
  task automatic wait_sclk(input logic lvl, input string tag);
    logic p = bus.Clock_Muestreo;
    bit seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (bus.Clock_Muestreo === lvl && p !== lvl) seen = 1;
      p = bus.Clock_Muestreo;
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask
  task automatic wait_cs_low(input string tag);
    bit seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (bus.CS === 1'b0) seen = 1;
    end
    if (!seen) check({tag, "_cs_timeout"}, 32'd0, 32'd1);
  endtask
  task automatic wait_rises(input int k, input string tag);
    logic p = bus.Clock_Muestreo;
    int r = 0;
    for (int n = 0; n < 400 && r < k; n++) begin
      @(negedge clk);
      if (!bus.CS && !p && bus.Clock_Muestreo) r++;
      p = bus.Clock_Muestreo;
    end
    if (r < k) check({tag, "_rise_timeout"}, 32'(r), 32'(k));
  endtask
  task automatic wait_done(input int k, input string tag);
    int d = 0;
    for (int n = 0; n < 2000 && d < k; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) d++;
    end
    if (d < k) check({tag, "_done_timeout"}, 32'(d), 32'(k));
  endtask
  task automatic begin_frame(input logic [15:0] w, input bit expect_result, input string tag);
    words_q.push_back(w);
    if (expect_result) exp_q.push_back(w);
    wait_sclk(1'b0, tag);
    bus.start = 1'b1;
    wait_cs_low(tag);
    bus.start = 1'b0;
  endtask
  initial begin
    longint t0;
    int d;
    bus.start  = 1'b0;
    Reset      = 1'b1;
    reset_Clck = 1'b1;
    #10;
    Reset      = 1'b0;
    reset_Clck = 1'b0;
    #1;
    check("reset_cs", 32'(bus.CS), 32'd1);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_dato", 32'(bus.Dato), 32'h000);
    check("reset_basura", 32'(bus.data_basura), 32'h0);
    check("reset_sclk", 32'(bus.Clock_Muestreo), 32'd0);
    wait_sclk(1'b1, "period_a");
    t0 = $time;
    wait_sclk(1'b0, "period_b");
    check("sclk_high_ns", 32'($time - t0), 32'd50);
    wait_sclk(1'b1, "period_c");
    check("sclk_period_ns", 32'($time - t0), 32'd100);
    begin_frame(16'h0AAA, 1, "f_aaa");
    wait_done(1, "f_aaa");
    check("dato_aaa", 32'(bus.Dato), 32'hAAA);
    check("basura_aaa", 32'(bus.data_basura), 32'h0);
    begin_frame(16'h0555, 1, "f_555");
    wait_rises(8, "f_555");
    check("dato_hold_aaa", 32'(bus.Dato), 32'hAAA);
    wait_done(1, "f_555");
    check("dato_555", 32'(bus.Dato), 32'h555);
    words_q.push_back(16'h0F0F); exp_q.push_back(16'h0F0F);
    words_q.push_back(16'h0ABC); exp_q.push_back(16'h0ABC);
    words_q.push_back(16'h0001); exp_q.push_back(16'h0001);
    wait_sclk(1'b0, "b2b");
    bus.start = 1'b1;
    wait_done(3, "b2b");
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    check("b2b_no_extra_frame", 32'(bus.CS), 32'd1);
    check("b2b_queue_drained", 32'(exp_q.size()), 32'd0);
    begin_frame(16'h0F00, 0, "abort");
    wait_rises(8, "abort");
    Reset = 1'b1;
    #1;
    check("abort_cs", 32'(bus.CS), 32'd1);
    check("abort_dato", 32'(bus.Dato), 32'h000);
    check("abort_basura", 32'(bus.data_basura), 32'h0);
    @(negedge clk);
    Reset = 1'b0;
    d = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.done === 1'b1) d++;
    end
    check("abort_no_done", 32'(d), 32'd0);
    check("abort_idle_cs", 32'(bus.CS), 32'd1);
    begin_frame(16'h0C3C, 1, "after_abort");
    wait_done(1, "after_abort");
    check("dato_after_abort", 32'(bus.Dato), 32'hC3C);
    begin_frame(16'h0E71, 1, "stall");
    wait_rises(4, "stall");
    reset_Clck = 1'b1;
    repeat (30) @(negedge clk);
    check("stall_sclk_low", 32'(bus.Clock_Muestreo), 32'd0);
    check("stall_cs_low", 32'(bus.CS), 32'd0);
    reset_Clck = 1'b0;
    wait_done(1, "stall");
    check("dato_after_stall", 32'(bus.Dato), 32'hE71);
    begin_frame(16'hBFFF, 1, "lead");
    wait_done(1, "lead");
    check("basura_b", 32'(bus.data_basura), 32'hB);
    check("dato_fff", 32'(bus.Dato), 32'hFFF);
    repeat (5) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prueba_adc.md
Name: prueba_adc

Overview:
- Serial-ADC front end for a 12-bit converter framed as 4 leading zero bits followed by 12 data bits, MSB first, for 16 SCLK cycles per frame (AD7476/Pmod-AD1 style).
- Generates the sample clock Clock_Muestreo from the board clock and drives chip-select CS.
- Shifts in data_ADC and presents the 12-bit result on Dato with a done strobe.
- Sits between the board ADC pins and downstream sample-processing logic.

Parameters:
- CLK_DIV, 5, number of Clock_Nexys cycles per Clock_Muestreo half-period (default gives 10 MHz from 100 MHz).
- FRAME_BITS, 16, total SCLK rising edges per conversion (4 leading + 12 data).

Ports:
- Clock_Nexys  in  1  system clock (100 MHz); the only clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset of the conversion FSM, counters, shift register and outputs.
- reset_Clck  in  1  asynchronous, active-high reset of the Clock_Muestreo divider only.
- data_ADC  in  1  serial data from the ADC; changes after a Clock_Muestreo falling edge.
- start  in  1  level request; high while idle starts a conversion.
- done  out  1  one-Clock_Nexys-cycle pulse when a frame completes.
- CS  out  1  ADC chip select, active low.
- Clock_Muestreo  out  1  generated serial clock (SCLK), 50% duty, free-running.
- data_basura  out  4  the 4 leading bits of the last frame (expected 0).
- Dato  out  12  the 12 data bits of the last frame; bit 11 is the first data bit received.

Behaviour:
- Clock divider: counter 0..CLK_DIV-1 in the Clock_Nexys domain; Clock_Muestreo toggles when the counter wraps. reset_Clck (or Reset) forces counter=0 and Clock_Muestreo=0.
- Internal single-cycle ticks:
  - rise_tick fires on the Clock_Nexys cycle that drives Clock_Muestreo 0->1.
  - fall_tick fires on the cycle that drives it 1->0.
  - No gated or derived clocks are used for logic.
- Reset values: CS=1, done=0, Dato=0, data_basura=0, shift register=0, bit counter=0, state=IDLE.
- FSM states IDLE, CONV, FINISH:
  - IDLE: CS=1. When start=1 and Clock_Muestreo=0, CS<=0 on that Clock_Nexys edge and go to CONV with bit counter=0.
  - CONV: on each rise_tick, shift data_ADC into the LSB of the 16-bit shift register and increment the counter. After the 16th rise_tick, go to FINISH.
  - FINISH: on the next fall_tick, CS<=1, data_basura<=sr[15:12], Dato<=sr[11:0], done<=1 for exactly one Clock_Nexys cycle, then go to IDLE.
- Bit mapping: rising edges 1-4 capture the leading zeros; edge 5 captures Dato[11]; edge 16 captures Dato[0].
- Dato and data_basura hold their value until the next frame completes or Reset asserts.
- start deassertion during CONV has no effect; the frame always completes.
- start still high on return to IDLE: a new frame begins only after CS has been high for at least one full Clock_Muestreo period, which guarantees the ADC quiet time.
- Reset asserted mid-frame: immediate abort, CS=1, all outputs to reset values. The next frame needs start again.
- reset_Clck asserted mid-frame: SCLK is held low and the FSM stalls. The frame resumes when it is released.
- data_ADC is sampled only on rise_tick and ignored while CS=1.

Test Plan:
- Reset/reset_Clck high 10 ns then low -> CS=1, done=0, Dato=0x000. Clock_Muestreo toggles every 50 ns (100 ns period).
- start=1 after a Clock_Muestreo falling edge; 4 zero bits, then data 1,0,1,0,... (12 bits) presented on falling edges; start=0 with the last bit -> CS low for 16 SCLK cycles, then CS=1, done pulses one cycle, Dato=0xAAA, data_basura=0x0.
- Second frame with pattern 0,1,0,1,... -> Dato=0x555, data_basura=0x0; 0xAAA held on Dato until this update.
- start held high continuously -> back-to-back frames separated by at least one SCLK period with CS=1; done pulses once per frame.
- Reset asserted at the 8th SCLK of a frame -> CS=1 immediately, Dato=0x000, no done pulse. A fresh start yields a correct result.
- Leading bits driven 1,0,1,1 with data 0xFFF -> data_basura=0xB, Dato=0xFFF.
